// File: rtl/fsm_soc_pkg.sv
// Shared definitions for the memory arbiter and its watchdog: state
// encodings, grant bit positions and the default timed-out read value.
package fsm_soc_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_BUSY_CPU = 2'd1;
   localparam logic [1:0] ST_BUSY_FSM = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE     = ST_IDLE,
      S_BUSY_CPU = ST_BUSY_CPU,
      S_BUSY_FSM = ST_BUSY_FSM
   } arb_state_e;

   // Which requester held the port most recently (round-robin pointer).
   typedef enum logic {
      RR_CPU = 1'b0,
      RR_FSM = 1'b1
   } rr_owner_e;

   localparam int GNT_CPU = 0;
   localparam int GNT_FSM = 1;

   // Counter width for watchdogs; covers timeouts up to 65535 cycles.
   localparam int WD_CNT_W = 16;

   localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog. Counts enabled cycles from zero and flags expire in
// the enabled cycle where the count reaches LIMIT-1. clear wins over enable
// and returns the count to zero for the next access.
module arb_watchdog
   import fsm_soc_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [WD_CNT_W-1:0] LAST = WD_CNT_W'(LIMIT - 1);

   logic [WD_CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear has priority, otherwise advance while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Expire only while counting, so an idle counter never fires.
   always_comb begin
      expire = enable && (cnt_q == LAST);
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fsm_mem_arbiter.sv
// Round-robin arbiter sharing one native memory port between the CPU and
// the fsm_overlay engine. One access in flight at a time; an IDLE cycle
// separates every pair of accesses. A watchdog forces completion of any
// access the memory never acknowledges so no requester can hang.
//
// Handshake: a requester raises x_valid with stable fields and holds them
// until x_ready; x_ready is a single-cycle pulse and x_rdata is meaningful
// only in that cycle. On the memory side mem_valid stays high with stable
// fields until the cycle in which mem_ready is sampled high (or the
// watchdog expires); mem_ready outside a BUSY state is ignored.
module fsm_mem_arbiter
   import fsm_soc_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 32,
   parameter int                TIMEOUT_CYC  = 255,
   parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(DEFAULT_TIMEOUT_DATA)
) (
   input  logic                clk,
   input  logic                rst_n,

   input  logic                cpu_valid,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   input  logic [DATA_W/8-1:0] cpu_wstrb,
   output logic                cpu_ready,
   output logic [DATA_W-1:0]   cpu_rdata,

   input  logic                fsm_valid,
   input  logic [ADDR_W-1:0]   fsm_addr,
   input  logic [DATA_W-1:0]   fsm_wdata,
   input  logic [DATA_W/8-1:0] fsm_wstrb,
   output logic                fsm_ready,
   output logic [DATA_W-1:0]   fsm_rdata,

   output logic                mem_valid,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata,

   output logic [1:0]          grant,
   output logic                timeout_err,
   output logic [1:0]          state_dbg
);

   arb_state_e  state_q, state_d;
   rr_owner_e   rr_last_q, rr_last_d;
   logic [1:0]  grant_q, grant_d;
   logic        mem_valid_q, mem_valid_d;

   logic              busy;
   logic              expire;
   logic              timed_out;
   logic              done;
   logic [DATA_W-1:0] resp_data;

   // Watchdog runs only while the port is owned and restarts on completion.
   arb_watchdog #(
      .LIMIT (TIMEOUT_CYC)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (done),
      .enable (busy),
      .expire (expire)
   );

   // Completion qualifiers; a coinciding mem_ready beats the watchdog.
   always_comb begin
      busy      = (state_q != S_IDLE);
      timed_out = busy && expire && !mem_ready;
      done      = busy && (mem_ready || expire);
      resp_data = timed_out ? TIMEOUT_DATA : mem_rdata;
   end

   // Next-state, round-robin pointer and registered port-ownership outputs.
   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      case (state_q)
         S_IDLE: begin
            if (cpu_valid && (!fsm_valid || rr_last_q == RR_FSM)) begin
               state_d   = S_BUSY_CPU;
               rr_last_d = RR_CPU;
            end else if (fsm_valid) begin
               state_d   = S_BUSY_FSM;
               rr_last_d = RR_FSM;
            end
         end
         S_BUSY_CPU, S_BUSY_FSM: begin
            if (done) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      grant_d          = 2'b00;
      grant_d[GNT_CPU] = (state_d == S_BUSY_CPU);
      grant_d[GNT_FSM] = (state_d == S_BUSY_FSM);
      mem_valid_d      = (state_d != S_IDLE);
   end

   // Arbiter FSM: state, fairness pointer and registered grant/mem_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rr_last_q   <= RR_FSM;
         grant_q     <= 2'b00;
         mem_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_last_q   <= rr_last_d;
         grant_q     <= grant_d;
         mem_valid_q <= mem_valid_d;
      end
   end

   // Shared-port field mux; fields read as zero while idle.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      case (state_q)
         S_BUSY_CPU: begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wstrb = cpu_wstrb;
         end
         S_BUSY_FSM: begin
            mem_addr  = fsm_addr;
            mem_wdata = fsm_wdata;
            mem_wstrb = fsm_wstrb;
         end
         default: begin
            mem_addr  = '0;
            mem_wdata = '0;
            mem_wstrb = '0;
         end
      endcase
   end

   // Response steering; the requester not being served sees zeros.
   always_comb begin
      cpu_ready   = done && (state_q == S_BUSY_CPU);
      fsm_ready   = done && (state_q == S_BUSY_FSM);
      cpu_rdata   = cpu_ready ? resp_data : '0;
      fsm_rdata   = fsm_ready ? resp_data : '0;
      timeout_err = timed_out;
   end

   assign mem_valid = mem_valid_q;
   assign grant     = grant_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_fsm_mem_arbiter.sv
// Directed bench for fsm_mem_arbiter with a scoreboard of expected grants
// and read data. Inputs change and outputs are sampled around the falling
// clock edge, well away from the active rising edge.
module tb_fsm_mem_arbiter;
  import fsm_soc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_valid = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        fsm_valid = 1'b0;
  logic [31:0] fsm_addr = '0;
  logic [31:0] fsm_wdata = '0;
  logic [3:0]  fsm_wstrb = '0;
  logic        fsm_ready;
  logic [31:0] fsm_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  grant;
  logic        timeout_err;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int lat;

  logic [31:0] exp_q[$];
  logic [1:0]  gnt_q[$];

  fsm_mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_valid   (cpu_valid),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wstrb   (cpu_wstrb),
    .cpu_ready   (cpu_ready),
    .cpu_rdata   (cpu_rdata),
    .fsm_valid   (fsm_valid),
    .fsm_addr    (fsm_addr),
    .fsm_wdata   (fsm_wdata),
    .fsm_wstrb   (fsm_wstrb),
    .fsm_ready   (fsm_ready),
    .fsm_rdata   (fsm_rdata),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .grant       (grant),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Global time bound
  initial begin
    #200000;
    $display("FAIL sim_timeout: observed=running expected=finished");
    $fatal(1, "simulation time bound exceeded");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Serve one access as the memory: wait for the grant, answer after
  // 'waits' wait cycles (or never), check the response against the
  // scoreboard, then check the mandatory idle cycle.
  task automatic serve(input int waits, input bit never, input int exp_b,
                       input bit exp_to, input bit drop, output int wait_out);
    int          wc;
    bit          done;
    logic [31:0] e_rd;
    logic [1:0]  e_g;
    wc = 0;
    done = 1'b0;
    while (mem_valid !== 1'b1 && wc < 20) begin
      @(negedge clk);
      wc++;
    end
    wait_out = wc;
    check("mem_valid_rise", {31'd0, mem_valid}, 32'd1);
    if (exp_q.size() == 0 || gnt_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e_rd = exp_q.pop_front();
    e_g  = gnt_q.pop_front();
    check("grant", {30'd0, grant}, {30'd0, e_g});
    check("state_dbg", {30'd0, state_dbg},
          {30'd0, (e_g == 2'b01) ? ST_BUSY_CPU : ST_BUSY_FSM});
    check("mem_addr", mem_addr, (e_g == 2'b01) ? cpu_addr : fsm_addr);
    check("mem_wdata", mem_wdata, (e_g == 2'b01) ? cpu_wdata : fsm_wdata);
    check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, (e_g == 2'b01) ? cpu_wstrb : fsm_wstrb});
    for (int b = 1; b <= 40 && !done; b++) begin
      mem_ready = !never && (b == waits + 1);
      mem_rdata = never ? ~e_rd : e_rd;
      #1;
      if (cpu_ready === 1'b1 || fsm_ready === 1'b1) begin
        done = 1'b1;
        check("done_cycle", 32'(b), 32'(exp_b));
        check("timeout_err", {31'd0, timeout_err}, {31'd0, exp_to});
        check("ready_owner", {30'd0, fsm_ready, cpu_ready}, {30'd0, e_g});
        check("rdata", (e_g == 2'b01) ? cpu_rdata : fsm_rdata, e_rd);
        check("other_rdata", (e_g == 2'b01) ? fsm_rdata : cpu_rdata, 32'd0);
        if (drop) begin
          cpu_valid = 1'b0;
          fsm_valid = 1'b0;
        end
      end else begin
        check("no_early_err", {31'd0, timeout_err}, 32'd0);
      end
      @(negedge clk);
    end
    if (!done) check("completion", 32'd0, 32'd1);
    mem_ready = 1'b0;
    #1;
    check("idle_gap_grant", {30'd0, grant}, 32'd0);
    check("idle_gap_valid", {31'd0, mem_valid}, 32'd0);
  endtask

  // Directed sequence
  initial begin
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_fsm_ready", {31'd0, fsm_ready}, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    rst_n = 1'b1;
    @(negedge clk);

    // CPU zero-wait read: ready in the second cycle of the request
    cpu_addr = 32'h0000_0100; cpu_wdata = '0; cpu_wstrb = 4'b0000;
    cpu_valid = 1'b1;
    exp_q.push_back(32'h1234_5678); gnt_q.push_back(2'b01);
    serve(0, 1'b0, 1, 1'b0, 1'b1, lat);
    check("t1_latency", 32'(lat), 32'd1);

    // FSM full-word write
    fsm_addr = 32'h2000_0000; fsm_wdata = 32'hA5A5_A5A5; fsm_wstrb = 4'b1111;
    fsm_valid = 1'b1;
    exp_q.push_back(32'h0000_1111); gnt_q.push_back(2'b10);
    serve(0, 1'b0, 1, 1'b0, 1'b1, lat);

    // Both held for four 1-wait accesses: strict alternation, CPU first
    cpu_addr = 32'h0000_0104; cpu_wstrb = 4'b0000;
    fsm_addr = 32'h2000_0004; fsm_wdata = 32'h0; fsm_wstrb = 4'b0000;
    cpu_valid = 1'b1; fsm_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'hC0DE_0000 + 32'(i));
      gnt_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
    end
    for (int i = 0; i < 4; i++) begin
      serve(1, 1'b0, 2, 1'b0, (i == 3), lat);
    end

    // Watchdog: no acknowledge, forced completion on 8th busy cycle
    cpu_addr = 32'h0000_0200; cpu_valid = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF); gnt_q.push_back(2'b01);
    serve(0, 1'b1, 8, 1'b1, 1'b1, lat);

    // Acknowledge coinciding with the timeout: normal completion
    cpu_addr = 32'h0000_0204; cpu_valid = 1'b1;
    exp_q.push_back(32'h55AA_55AA); gnt_q.push_back(2'b01);
    serve(7, 1'b0, 8, 1'b0, 1'b1, lat);

    // Reset in the middle of a slow FSM access
    fsm_addr = 32'h2000_0010; fsm_wstrb = 4'b0000; fsm_valid = 1'b1;
    lat = 0;
    while (mem_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t6_busy_fsm", {30'd0, grant}, 32'd2);
    repeat (2) @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'h7777_7777;
    rst_n = 1'b0;
    #1;
    check("t6_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("t6_grant", {30'd0, grant}, 32'd0);
    check("t6_fsm_ready", {31'd0, fsm_ready}, 32'd0);
    check("t6_fsm_rdata", fsm_rdata, 32'd0);
    check("t6_mem_addr", mem_addr, 32'd0);
    check("t6_timeout", {31'd0, timeout_err}, 32'd0);
    fsm_valid = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie after reset: CPU first, then FSM
    cpu_addr = 32'h0000_0300; cpu_wstrb = 4'b0000;
    fsm_addr = 32'h2000_0020; fsm_wstrb = 4'b0000;
    cpu_valid = 1'b1; fsm_valid = 1'b1;
    exp_q.push_back(32'h0000_AAAA); gnt_q.push_back(2'b01);
    exp_q.push_back(32'h0000_BBBB); gnt_q.push_back(2'b10);
    serve(0, 1'b0, 1, 1'b0, 1'b0, lat);
    serve(0, 1'b0, 1, 1'b0, 1'b1, lat);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_mem_arbiter.md
Name: fsm_mem_arbiter

Overview:
- Shares one native-style memory port between two requesters: the PicoRV32 core (cpu_*) and the fsm_overlay control engine (fsm_*).
- Uses round-robin arbitration with one outstanding transaction at a time.
- A watchdog completes any access the memory never acknowledges, so neither requester can hang.
- Sits between fsm_overlay, picorv32 and the shared RAM/peripheral bus in the top level.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; the strobe width is DATA_W/8.
- TIMEOUT_CYC, 255, number of cycles after mem_valid rises before a forced completion; legal range 1..65535.
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on a timed-out access.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_valid  in  1  CPU request; held high with stable fields until cpu_ready.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_wstrb  in  DATA_W/8  CPU byte strobes; all zero means a read.
- cpu_ready  out  1  one-cycle completion pulse to the CPU.
- cpu_rdata  out  DATA_W  CPU read data; valid only while cpu_ready is high.
- fsm_valid, fsm_addr, fsm_wdata, fsm_wstrb  in  1/ADDR_W/DATA_W/DATA_W/8  FSM request, with the same rules as the CPU request.
- fsm_ready  out  1  one-cycle completion pulse to the FSM.
- fsm_rdata  out  DATA_W  FSM read data; valid only while fsm_ready is high.
- mem_valid  out  1  shared-port request.
- mem_addr, mem_wdata, mem_wstrb  out  ADDR_W/DATA_W/DATA_W/8  shared-port fields.
- mem_ready  in  1  memory completion.
- mem_rdata  in  DATA_W  memory read data.
- grant  out  2  one-hot owner of the port: bit0 = CPU, bit1 = FSM; 00 when idle.
- timeout_err  out  1  one-cycle pulse on a forced completion.

Behaviour:
- Reset (asynchronous):
  - state IDLE, grant = 00, mem_valid = 0, mem_* fields = 0, both ready outputs = 0, timeout_err = 0, watchdog = 0.
  - rr_last = FSM, so the CPU wins the first tie.
- State machine: IDLE, BUSY_CPU, BUSY_FSM.
- IDLE:
  - Only cpu_valid: go to BUSY_CPU.
  - Only fsm_valid: go to BUSY_FSM.
  - Both valid: grant the requester that is not rr_last.
  - On entering BUSY_x, update rr_last to x.
  - mem_ready is ignored in IDLE.
- BUSY_x:
  - mem_valid = 1, and mem_addr/wdata/wstrb are muxed combinationally from requester x.
  - grant reflects x.
  - The watchdog increments every BUSY cycle.
- Normal completion:
  - In the cycle where mem_ready = 1: x_ready = 1 combinationally and x_rdata = mem_rdata.
  - The next state is IDLE.
- Timeout:
  - When the watchdog reaches TIMEOUT_CYC-1 with mem_ready still 0, that cycle x_ready = 1, x_rdata = TIMEOUT_DATA and timeout_err = 1.
  - The next state is IDLE and the watchdog clears.
  - If mem_ready and the timeout coincide, mem_ready wins: normal completion, no error.
- Latency:
  - The arbitration decision registers one cycle after valid.
  - The minimum access is 2 cycles from request to ready; this is zero-wait memory, with mem_ready high in the first BUSY cycle.
  - A new grant is issued at the earliest one cycle after completion; the IDLE cycle is mandatory.
- Fairness:
  - With both requesters continuously valid, grants strictly alternate.
  - The maximum wait for either requester is one foreign transaction.
- The non-granted requester always sees ready = 0 and rdata = 0.
- Protocol violation: if a requester drops valid while granted, the arbiter still finishes the access and pulses ready. The state is not corrupted.
- Reset mid-access: all outputs return to reset values immediately; the pending access is abandoned with no ready pulse.

Decomposition:
- Shared package fsm_soc_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_BUSY_CPU = 2'd1, ST_BUSY_FSM = 2'd2;
  - grant bit indices GNT_CPU = 0, GNT_FSM = 1;
  - the default TIMEOUT_DATA.
- One sub-module is natural: arb_watchdog, a loadable TIMEOUT_CYC counter with clear/enable/expire. It is reusable for future bus bridges.
- The mux and FSM stay in the top.

Test Plan:
1. Reset release, CPU read at addr 0x100 with mem_ready at the 1st BUSY cycle and mem_rdata 0x12345678 -> cpu_ready pulse at cycle 2, cpu_rdata = 0x12345678, grant = 01 only during BUSY, fsm_ready stays 0.
2. cpu_valid and fsm_valid asserted together and held for 4 transactions, memory 1-wait -> grant order CPU, FSM, CPU, FSM, one IDLE cycle between each.
3. FSM write addr 0x2000_0000, wdata 0xA5A5A5A5, wstrb 4'b1111 -> mem_addr/wdata/wstrb match exactly while mem_valid is high, fsm_ready pulses once.
4. TIMEOUT_CYC = 8, mem_ready never asserted on a CPU read -> cpu_ready and timeout_err pulse together on the 8th BUSY cycle, cpu_rdata = 0xDEADBEEF, port back in IDLE next cycle.
5. TIMEOUT_CYC = 8, mem_ready asserted exactly on the 8th BUSY cycle -> normal completion, timeout_err = 0.
6. rst_n pulled low during BUSY_FSM with a 5-wait memory -> mem_valid, grant and ready drop asynchronously. After release, a CPU+FSM tie grants the CPU first.
